// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer initiator.
// Accepts one command on a valid/ready port, runs one WB cycle and returns
// read data / error status on a valid/ready response port.
// Optional build macro WBM_TIMEOUT_EN: abort a WB cycle that sees no ack/err
// within TIMEOUT strobe cycles and report it as an error with all-ones data.

module wb_cmd_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned SW     = DW / 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  // command port
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [SW-1:0] cmd_sel,
  input  logic [AW-1:0] cmd_adr,
  input  logic [DW-1:0] cmd_dat,
  // response port
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_dat,
  output logic          rsp_err,
  // Wishbone master
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [SW-1:0] wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  input  logic [DW-1:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] to_cnt;
`else
  // TIMEOUT only matters when the watchdog is built in
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT);
`endif

  // A new command is taken only while no transfer is in flight
  assign cmd_ready = (state == IDLE);

  // Transfer sequencer: latch command, run the WB cycle, hold the response
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= BUS;
          end
        end

        BUS: begin
          if (wbm_ack_i || wbm_err_i) begin
            // ack wins when the slave raises both
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            rsp_err   <= wbm_err_i & ~wbm_ack_i;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef WBM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= '1;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            to_cnt    <= to_cnt + CW'(1);
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: table of single transfers plus hand-written
// sequences for response back-pressure, timeout and reset during a transfer.

module tb_wb_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] wbm_dat_i;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          wait_n;   // stb cycles before the slave answers
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    int          exp_stb;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t tbl[6];

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_dat_i (wbm_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_t x;
    x.dat = d;
    x.err = e;
    sb.push_back(x);
  endtask

  // Scoreboard: every response handshake must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got dat=%0h err=%0b expected no response", rsp_dat, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Run one transfer with rsp_ready held high; called at posedge+1
  task automatic do_xfer(input vec_t v);
    int n;
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_sel   = v.sel;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    push_exp(v.exp_dat, v.exp_err);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we    = ~v.we;
    cmd_sel   = ~v.sel;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    n = 0;
    while (wbm_stb_o && n < 200) begin
      n++;
      chk("cyc_eq_stb", 64'(wbm_cyc_o), 64'd1);
      chk("wb_we",  64'(wbm_we_o),  64'(v.we));
      chk("wb_sel", 64'(wbm_sel_o), 64'(v.sel));
      chk("wb_adr", 64'(wbm_adr_o), 64'(v.adr));
      chk("wb_dat", 64'(wbm_dat_o), 64'(v.dat));
      chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (n == v.wait_n + 1) begin
        wbm_ack_i = v.ack;
        wbm_err_i = v.err;
        wbm_dat_i = v.rdat;
      end
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = 32'hDEAD_BEEF;
    end
    chk("stb_cycles", 64'(n), 64'(v.exp_stb));
    chk("cyc_done", 64'(wbm_cyc_o), 64'd0);
    chk("rsp_valid_up", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    chk("rsp_valid_down", 64'(rsp_valid), 64'd0);
    chk("cmd_ready_next", 64'(cmd_ready), 64'd1);
  endtask

  // Hard stop if something hangs beyond all bounded waits
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          we    sel    adr            dat            wt ack   err   rdat           stb exp_dat        exp_err
    tbl[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hCAFE_F00D, 0, 1'b1, 1'b0, 32'h5555_AAAA, 1, 32'h0000_0000, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0000_0000, 3, 1'b1, 1'b0, 32'h1234_5678, 4, 32'h1234_5678, 1'b0};
    tbl[2] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0000_0000, 1, 1'b0, 1'b1, 32'hFFFF_0000, 2, 32'h0000_0000, 1'b1};
    tbl[3] = '{1'b0, 4'hC, 32'h3000_000C, 32'h0000_0000, 0, 1'b1, 1'b1, 32'hA5A5_A5A5, 1, 32'hA5A5_A5A5, 1'b0};
    tbl[4] = '{1'b1, 4'h1, 32'h3000_0014, 32'h0000_00EE, 2, 1'b0, 1'b1, 32'h7777_7777, 3, 32'h0000_0000, 1'b1};
    tbl[5] = '{1'b1, 4'h3, 32'h3000_0018, 32'hBEEF_0001, 1, 1'b1, 1'b1, 32'h1357_9BDF, 2, 32'h0000_0000, 1'b0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = '0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b1;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;

    // reset state
    #1;
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_we",  64'(wbm_we_o),  64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_sel", 64'(wbm_sel_o), 64'd0);
    chk("rst_dato", 64'(wbm_dat_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // table of single transfers
    for (int i = 0; i < 6; i++) do_xfer(tbl[i]);

    // response back-pressure with the next command already waiting
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'h3;
    cmd_adr   = 32'h3000_0010;
    cmd_dat   = 32'h0;
    push_exp(32'h0BAD_C0DE, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_stb", 64'(wbm_stb_o), 64'd1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0BAD_C0DE;
    @(posedge clk); #1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_sel   = 4'hF;
    cmd_adr   = 32'h3000_0020;
    cmd_dat   = 32'h1111_2222;
    push_exp(32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wbm_err_i = 1'b1;   // stray error outside BUS must be ignored
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_dat", 64'(rsp_dat), 64'h0BAD_C0DE);
      chk("bp_rsp_err", 64'(rsp_err), 64'd0);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_stb_low", 64'(wbm_stb_o), 64'd0);
      @(posedge clk); #1;
    end
    wbm_err_i = 1'b0;
    rsp_ready = 1'b1;
    chk("bp_rsp_valid_last", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_rsp_done", 64'(rsp_valid), 64'd0);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp2_stb", 64'(wbm_stb_o), 64'd1);
    chk("bp2_adr", 64'(wbm_adr_o), 64'h3000_0020);
    chk("bp2_we",  64'(wbm_we_o),  64'd1);
    chk("bp2_dat", 64'(wbm_dat_o), 64'h1111_2222);
    wbm_ack_i = 1'b1;
    @(posedge clk); #1;
    wbm_ack_i = 1'b0;
    chk("bp2_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp2_rsp_done", 64'(rsp_valid), 64'd0);

`ifdef WBM_TIMEOUT_EN
    // no answer: abort after 8 strobe cycles
    v = '{1'b0, 4'hF, 32'h3000_0008, 32'h0, 0, 1'b0, 1'b0, 32'h0, 8, 32'hFFFF_FFFF, 1'b1};
    do_xfer(v);
    // ack on the timeout edge completes normally
    v = '{1'b0, 4'hF, 32'h3000_000C, 32'h0, 7, 1'b1, 1'b0, 32'h7777_8888, 8, 32'h7777_8888, 1'b0};
    do_xfer(v);
`endif

    // reset while the WB cycle is open; without the watchdog it must hang first
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_adr   = 32'h3000_0030;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
`ifdef WBM_TIMEOUT_EN
    repeat (3) @(posedge clk);
`else
    repeat (120) @(posedge clk);
`endif
    #1;
    chk("hang_stb", 64'(wbm_stb_o), 64'd1);
    chk("hang_cyc", 64'(wbm_cyc_o), 64'd1);
    chk("hang_no_rsp", 64'(rsp_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("arst_stb", 64'(wbm_stb_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    end
    do_xfer(tbl[1]);

    @(posedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
